// File: rtl/mem_access.sv
// mem_access: MEM-stage load/store unit bridging the EX/MEM register to a
// 64-bit data bus. IDLE/BUSY/DONE handshake, byte-lane steering, load
// sign/zero extension and misalignment detection.
// Optional bus timeout: define MEM_ACCESS_TIMEOUT_EN to abort BUSY after
// 255 cycles without ack_i and flag bus_err_o for the DONE cycle.
module mem_access (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  funct3_i,
   input  logic [4:0]  rd_idx_i,
   input  logic        wb_i,
   input  logic [63:0] result_i,
   input  logic        rmem_i,
   input  logic        wmem_i,
   input  logic [63:0] wmem_data_i,
   output logic        req_o,
   output logic        we_o,
   output logic [63:0] addr_o,
   output logic [63:0] wdata_o,
   output logic [7:0]  wstrb_o,
   input  logic [63:0] rdata_i,
   input  logic        ack_i,
   output logic        hold_o,
   output logic [4:0]  rd_idx_o,
   output logic        wb_o,
   output logic [63:0] wb_data_o,
   output logic        misalign_o,
   output logic        bus_err_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [63:0] addr_q;
   logic [63:0] sdata_q;
   logic [63:0] data_q;
   logic [1:0]  size_q;
   logic        uns_q;
   logic        store_q;
   logic        wb_q;
   logic [4:0]  rd_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
   logic [7:0]  cnt_q;
   logic        err_q;
`endif

   logic        access;
   logic        misal;
   logic [5:0]  lane_shift;
   logic [63:0] rdata_shifted;

   // True when the offset is not a multiple of the access size
   function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
      case (sz)
         2'b00:   is_misaligned = 1'b0;
         2'b01:   is_misaligned = off[0];
         2'b10:   is_misaligned = |off[1:0];
         default: is_misaligned = |off;
      endcase
   endfunction

   // Byte-enable pattern for an access of the given size at offset 0
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'b00:   size_mask = 8'h01;
         2'b01:   size_mask = 8'h03;
         2'b10:   size_mask = 8'h0F;
         default: size_mask = 8'hFF;
      endcase
   endfunction

   // Sign- or zero-extend the low bytes of an LSB-justified load value
   function automatic logic [63:0] extend(input logic [63:0] raw, input logic [1:0] sz,
                                          input logic uns);
      case (sz)
         2'b00:   extend = uns ? 64'(raw[7:0])  : {{56{raw[7]}},  raw[7:0]};
         2'b01:   extend = uns ? 64'(raw[15:0]) : {{48{raw[15]}}, raw[15:0]};
         2'b10:   extend = uns ? 64'(raw[31:0]) : {{32{raw[31]}}, raw[31:0]};
         default: extend = raw;
      endcase
   endfunction

   assign access        = rmem_i | wmem_i;
   assign misal         = is_misaligned(funct3_i[1:0], result_i[2:0]);
   assign lane_shift    = {addr_q[2:0], 3'b000};
   assign rdata_shifted = rdata_i >> lane_shift;

   // FSM and latched access context
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         sdata_q <= '0;
         data_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         store_q <= 1'b0;
         wb_q    <= 1'b0;
         rd_q    <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
         cnt_q   <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (access && !misal) begin
                  addr_q  <= result_i;
                  sdata_q <= wmem_data_i;
                  size_q  <= funct3_i[1:0];
                  uns_q   <= funct3_i[2];
                  store_q <= ~rmem_i;          // load wins when both are set
                  wb_q    <= wb_i;
                  rd_q    <= rd_idx_i;
                  state   <= BUSY;
`ifdef MEM_ACCESS_TIMEOUT_EN
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
`endif
               end
            end
            BUSY: begin
               if (ack_i) begin
                  data_q <= extend(rdata_shifted, size_q, uns_q);
                  state  <= DONE;
               end
`ifdef MEM_ACCESS_TIMEOUT_EN
               else if (cnt_q == 8'd254) begin
                  cnt_q  <= 8'd255;
                  err_q  <= 1'b1;
                  data_q <= '0;
                  state  <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Bus, stall and writeback outputs decoded from state and inputs
   always_comb begin
      req_o      = 1'b0;
      we_o       = 1'b0;
      addr_o     = {addr_q[63:3], 3'b000};
      wdata_o    = sdata_q << lane_shift;
      wstrb_o    = 8'h00;
      hold_o     = 1'b0;
      rd_idx_o   = rd_idx_i;
      wb_o       = wb_i;
      wb_data_o  = result_i;
      misalign_o = 1'b0;
      bus_err_o  = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               wb_o = 1'b0;
               if (misal) misalign_o = 1'b1;
               else       hold_o     = 1'b1;
            end
         end
         BUSY: begin
            req_o     = 1'b1;
            hold_o    = 1'b1;
            we_o      = store_q;
            wstrb_o   = size_mask(size_q) << addr_q[2:0];
            rd_idx_o  = rd_q;
            wb_o      = 1'b0;
            wb_data_o = addr_q;
         end
         default: begin
            rd_idx_o = rd_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
            if (err_q) begin
               bus_err_o = 1'b1;
               wb_o      = 1'b0;
               wb_data_o = '0;
            end else
`endif
            if (store_q) begin
               wb_o      = 1'b0;
               wb_data_o = addr_q;
            end else begin
               wb_o      = wb_q;
               wb_data_o = data_q;
            end
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed testbench for mem_access.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  funct3_i;
   logic [4:0]  rd_idx_i;
   logic        wb_i;
   logic [63:0] result_i;
   logic        rmem_i;
   logic        wmem_i;
   logic [63:0] wmem_data_i;
   logic        req_o;
   logic        we_o;
   logic [63:0] addr_o;
   logic [63:0] wdata_o;
   logic [7:0]  wstrb_o;
   logic [63:0] rdata_i;
   logic        ack_i;
   logic        hold_o;
   logic [4:0]  rd_idx_o;
   logic        wb_o;
   logic [63:0] wb_data_o;
   logic        misalign_o;
   logic        bus_err_o;

   int n_cmp = 0;
   int n_err = 0;
   int hold_cnt = 0;

   always #5 clk = ~clk;

   mem_access dut (
      .clk(clk), .rst(rst), .funct3_i(funct3_i), .rd_idx_i(rd_idx_i), .wb_i(wb_i),
      .result_i(result_i), .rmem_i(rmem_i), .wmem_i(wmem_i), .wmem_data_i(wmem_data_i),
      .req_o(req_o), .we_o(we_o), .addr_o(addr_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o),
      .rdata_i(rdata_i), .ack_i(ack_i), .hold_o(hold_o), .rd_idx_o(rd_idx_o),
      .wb_o(wb_o), .wb_data_o(wb_data_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
   );

   // Count stalled cycles, sampled mid-cycle
   always @(negedge clk) if (hold_o === 1'b1) hold_cnt++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Load with ack in the first BUSY cycle; checks the DONE writeback value
   task automatic load1(input string tag, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] rd, input logic [63:0] exp);
      @(posedge clk) #1;
      funct3_i = f3; result_i = a; rmem_i = 1'b1; wb_i = 1'b1; rd_idx_i = 5'd9;
      @(posedge clk) #1;
      ack_i = 1'b1; rdata_i = rd;
      @(posedge clk) #1;
      ack_i = 1'b0; rmem_i = 1'b0;
      @(negedge clk);
      check(tag, wb_data_o, exp);
      check({tag, "_wb"}, 64'(wb_o), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen;
      rst = 1'b1; funct3_i = '0; rd_idx_i = '0; wb_i = 1'b0; result_i = '0;
      rmem_i = 1'b0; wmem_i = 1'b0; wmem_data_i = '0; rdata_i = '0; ack_i = 1'b0;
      @(negedge clk);
      check("rst_req", 64'(req_o), 64'd0);
      check("rst_hold", 64'(hold_o), 64'd0);
      check("rst_buserr", 64'(bus_err_o), 64'd0);
      @(posedge clk) #1;
      rst = 1'b0;

      // Passthrough when there is no memory access
      wb_i = 1'b1; result_i = 64'h55; rd_idx_i = 5'd7;
      @(negedge clk);
      check("pass_wb", 64'(wb_o), 64'd1);
      check("pass_data", wb_data_o, 64'h55);
      check("pass_rd", 64'(rd_idx_o), 64'd7);
      check("pass_hold", 64'(hold_o), 64'd0);

      // Load word, immediate ack
      @(posedge clk) #1;
      hold_cnt = 0;
      funct3_i = 3'b010; result_i = 64'h1004; rmem_i = 1'b1; wb_i = 1'b1; rd_idx_i = 5'd5;
      @(negedge clk);
      check("lw_idle_hold", 64'(hold_o), 64'd1);
      check("lw_idle_req", 64'(req_o), 64'd0);
      @(posedge clk) #1;
      ack_i = 1'b1; rdata_i = 64'hDEADBEEF_80000000;
      @(negedge clk);
      check("lw_req", 64'(req_o), 64'd1);
      check("lw_addr", addr_o, 64'h1000);
      check("lw_we", 64'(we_o), 64'd0);
      @(posedge clk) #1;
      ack_i = 1'b0; rmem_i = 1'b0; wb_i = 1'b0; result_i = '0; rd_idx_i = '0;
      @(negedge clk);
      check("lw_data", wb_data_o, 64'hFFFFFFFF_DEADBEEF);
      check("lw_wb", 64'(wb_o), 64'd1);
      check("lw_rd", 64'(rd_idx_o), 64'd5);
      check("lw_done_hold", 64'(hold_o), 64'd0);
      check("lw_hold_cycles", 64'(hold_cnt), 64'd2);

      // Store byte at offset 3
      @(posedge clk) #1;
      funct3_i = 3'b000; result_i = 64'h2003; wmem_i = 1'b1; wmem_data_i = 64'hAB;
      wb_i = 1'b1; rd_idx_i = 5'd3;
      @(posedge clk) #1;
      ack_i = 1'b1;
      @(negedge clk);
      check("sb_addr", addr_o, 64'h2000);
      check("sb_we", 64'(we_o), 64'd1);
      check("sb_wstrb", 64'(wstrb_o), 64'h08);
      check("sb_wdata", wdata_o, 64'hAB000000);
      @(posedge clk) #1;
      ack_i = 1'b0; wmem_i = 1'b0;
      @(negedge clk);
      check("sb_done_wb", 64'(wb_o), 64'd0);
      check("sb_done_data", wb_data_o, 64'h2003);

      // Misaligned load half
      @(posedge clk) #1;
      hold_cnt = 0;
      funct3_i = 3'b001; result_i = 64'h3001; rmem_i = 1'b1; wb_i = 1'b1; ack_i = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("mis_flag", 64'(misalign_o), 64'd1);
         check("mis_req", 64'(req_o), 64'd0);
         check("mis_wb", 64'(wb_o), 64'd0);
      end
      check("mis_hold_cycles", 64'(hold_cnt), 64'd0);
      @(posedge clk) #1;
      rmem_i = 1'b0; ack_i = 1'b0;

      // Size/sign extension variants
      load1("lb",  3'b000, 64'h4005, 64'h00009900_00000000, 64'hFFFFFFFF_FFFFFF99);
      load1("lbu", 3'b100, 64'h4005, 64'h00009900_00000000, 64'h99);
      load1("lh",  3'b001, 64'h5006, 64'h80010000_00000000, 64'hFFFFFFFF_FFFF8001);
      load1("lwu", 3'b110, 64'h1004, 64'hDEADBEEF_80000000, 64'hDEADBEEF);
      load1("ld",  3'b011, 64'h6000, 64'h01234567_89ABCDEF, 64'h01234567_89ABCDEF);

      // Load and store both requested: treated as a load
      @(posedge clk) #1;
      funct3_i = 3'b011; result_i = 64'h6008; rmem_i = 1'b1; wmem_i = 1'b1; wb_i = 1'b1;
      @(posedge clk) #1;
      ack_i = 1'b1; rdata_i = 64'h1122;
      @(negedge clk);
      check("both_we", 64'(we_o), 64'd0);
      @(posedge clk) #1;
      ack_i = 1'b0; rmem_i = 1'b0; wmem_i = 1'b0;
      @(negedge clk);
      check("both_data", wb_data_o, 64'h1122);

      // Load with ack in the fifth BUSY cycle
      @(posedge clk) #1;
      hold_cnt = 0;
      funct3_i = 3'b100; result_i = 64'h4005; rmem_i = 1'b1; wb_i = 1'b1; rd_idx_i = 5'd12;
      @(posedge clk);
      for (int k = 1; k <= 5; k++) begin
         #1;
         ack_i = (k == 5);
         rdata_i = (k == 5) ? 64'h00009900_00000000 : 64'hFFFFFFFF_FFFFFFFF;
         @(negedge clk);
         check("dly_req", 64'(req_o), 64'd1);
         check("dly_addr", addr_o, 64'h4000);
         check("dly_wstrb", 64'(wstrb_o), 64'h20);
         @(posedge clk);
      end
      #1;
      ack_i = 1'b0; rmem_i = 1'b0;
      @(negedge clk);
      check("dly_data", wb_data_o, 64'h99);
      check("dly_rd", 64'(rd_idx_o), 64'd12);
      check("dly_hold_cycles", 64'(hold_cnt), 64'd6);

      // Reset in the middle of BUSY
      @(posedge clk) #1;
      funct3_i = 3'b011; result_i = 64'h7000; rmem_i = 1'b1;
      @(posedge clk) #1;
      @(negedge clk);
      check("rstb_req_pre", 64'(req_o), 64'd1);
      @(posedge clk) #1;
      rst = 1'b1; rmem_i = 1'b0;
      #1;
      check("rstb_req", 64'(req_o), 64'd0);
      check("rstb_hold", 64'(hold_o), 64'd0);
      check("rstb_buserr", 64'(bus_err_o), 64'd0);
      @(posedge clk) #1;
      rst = 1'b0; result_i = 64'h77; ack_i = 1'b1;
      @(negedge clk);
      check("rstb_idle_req", 64'(req_o), 64'd0);
      check("rstb_idle_data", wb_data_o, 64'h77);
      @(posedge clk) #1;
      ack_i = 1'b0;

      // No ack ever
      @(posedge clk) #1;
      funct3_i = 3'b010; result_i = 64'h8000; rmem_i = 1'b1; wb_i = 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
      n = 0; seen = 1'b0;
      for (int k = 0; k < 400 && !seen; k++) begin
         @(negedge clk);
         if (req_o) n++;
         if (bus_err_o) begin
            seen = 1'b1;
            check("to_wb", 64'(wb_o), 64'd0);
            check("to_data", wb_data_o, 64'd0);
            check("to_hold", 64'(hold_o), 64'd0);
         end
      end
      rmem_i = 1'b0;
      check("to_seen", 64'(seen), 64'd1);
      check("to_busy_cycles", 64'(n), 64'd255);
      @(negedge clk);
      check("to_err_one_cycle", 64'(bus_err_o), 64'd0);
`else
      n = 0; seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (hold_o) n++;
         if (bus_err_o) seen = 1'b1;
      end
      check("nto_hold_cycles", 64'(n), 64'd300);
      check("nto_buserr", 64'(seen), 64'd0);
      rmem_i = 1'b0;
`endif
      @(posedge clk) #1;
      rst = 1'b1;
      @(posedge clk) #1;
      rst = 1'b0;
      @(negedge clk);
      check("end_req", 64'(req_o), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 SHALL have ports (name direction width meaning), clock and reset first; one clock, reset asynchronous and active-high:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- funct3_i  in  3  access size/sign, from EX/MEM register
- rd_idx_i  in  5  destination register
- wb_i  in  1  writeback enable
- result_i  in  64  ALU result / effective address
- rmem_i  in  1  load request
- wmem_i  in  1  store request
- wmem_data_i  in  64  store data, LSB-justified
- req_o  out  1  bus request
- we_o  out  1  bus write
- addr_o  out  64  bus address, 8-byte aligned
- wdata_o  out  64  lane-shifted store data
- wstrb_o  out  8  byte strobes
- rdata_i  in  64  bus read data
- ack_i  in  1  bus completion
- hold_o  out  1  stall to EX/MEM and upstream
- rd_idx_o  out  5  to MEM/WB
- wb_o  out  1  to MEM/WB
- wb_data_o  out  64  to MEM/WB
- misalign_o  out  1  misaligned-access flag
- bus_err_o  out  1  bus timeout flag

Function
REQ-002 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-003 Size SHALL come from funct3_i[1:0]: 00 byte, 01 half, 10 word, 11 dword. funct3_i[2]=1 on a load SHALL select zero-extension; stores ignore bit 2.
REQ-004 An access SHALL be misaligned when result_i[2:0] is not a multiple of the size.
REQ-005 IDLE, no access (rmem_i=wmem_i=0): hold_o=0, wb_o=wb_i, wb_data_o=result_i, rd_idx_o=rd_idx_i, all combinational.
REQ-006 IDLE, aligned access: hold_o=1 combinationally; latch address, size, sign, rd, wb and direction; next state BUSY.
REQ-007 IDLE, misaligned access: misalign_o=1 and wb_o=0 combinationally; req_o=0; hold_o=0; stay IDLE.
REQ-008 When rmem_i and wmem_i are both 1, the access SHALL be treated as a load.
REQ-009 BUSY SHALL drive req_o=1 and hold_o=1. Bus outputs SHALL be:
- addr_o = latched address with bits [2:0] cleared
- we_o = store
- wstrb_o = size mask (01/03/0F/FF) << addr[2:0]
- wdata_o = store data << 8*addr[2:0]
These outputs SHALL be stable until ack_i.
REQ-010 BUSY with ack_i=1: capture rdata_i >> 8*addr[2:0], extended per size/sign, into a 64-bit data register; next state DONE. ack_i outside BUSY SHALL be ignored.
REQ-011 DONE SHALL last exactly one cycle:
- hold_o=0, req_o=0
- wb_data_o = captured data on loads, latched result on stores
- wb_o = latched wb on loads, 0 on stores
- rd_idx_o = latched rd
Inputs SHALL be ignored in DONE; next state IDLE.
REQ-012 Minimum access latency SHALL be 3 cycles (IDLE, BUSY, DONE) when ack_i arrives in the first BUSY cycle.

Reset
REQ-013 rst SHALL force IDLE, clear all latched registers and the timeout counter, and drive req_o=0, bus_err_o=0 immediately, including mid-BUSY; a pending access is dropped.

Configuration
REQ-014 With macro MEM_ACCESS_TIMEOUT_EN defined:
- an 8-bit counter SHALL clear on BUSY entry and increment each BUSY cycle without ack_i
- at count 255: abort to DONE with bus_err_o=1 for that DONE cycle, wb_o=0, wb_data_o=0
Without the macro: BUSY SHALL wait indefinitely, and bus_err_o SHALL be tied 0.

Verification
REQ-015 Load word, funct3=010, result_i=0x1004, rdata_i=0xDEADBEEF_80000000, ack_i in first BUSY cycle -> addr_o=0x1000, DONE wb_data_o=0xFFFFFFFF_DEADBEEF, hold_o high exactly 2 cycles.
REQ-016 Store byte, funct3=000, result_i=0x2003, wmem_data_i=0xAB -> wstrb_o=0x08, wdata_o=0xAB000000, we_o=1, DONE wb_o=0.
REQ-017 Load half, funct3=001, result_i=0x3001 -> misalign_o=1, req_o never asserted, hold_o=0.
REQ-018 Load, ack_i delayed 5 cycles -> hold_o high 6 cycles, bus outputs constant throughout; then assert rst mid-BUSY -> req_o=0 immediately, FSM IDLE.
REQ-019 With MEM_ACCESS_TIMEOUT_EN defined and ack_i never asserted -> bus_err_o=1 for one cycle after 255 BUSY cycles, wb_o=0; without the macro -> hold_o stays 1.
